// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and default field widths for pipeline stage registers
package pipe_pkg;
  typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b01, FULL = 2'b11} state_t;
  localparam int DEF_CTRL_W = 8;
  localparam int DEF_DATA_W = 128;
  localparam int DEF_CNT_W  = 16;
endpackage

// File: rtl/d_ffec_n.sv
// d_ffec_n: N-bit D flop with enable and asynchronous active-low clear
module d_ffec_n #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with 2-entry skid buffer, flush-to-bubble
// and a saturating stall counter
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              Clk,
  input  logic              Clrn,
  input  logic              Flush,
  input  logic              InValid,
  output logic              InReady,
  input  logic [CTRL_W-1:0] InCtrl,
  input  logic [DATA_W-1:0] InData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [CTRL_W-1:0] OutCtrl,
  output logic [DATA_W-1:0] OutData,
  output logic [CNT_W-1:0]  StallCnt
);
  state_t state, state_nx;
  logic acc, xfer, ld_main, ld_skid, clr_main;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  assign OutValid = state != EMPTY;
  assign InReady  = state != FULL;
  assign acc      = InValid & InReady & !Flush;
  assign xfer     = OutValid & OutReady;
  always_ff @(posedge Clk or negedge Clrn)
    if (!Clrn) state <= EMPTY;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    ld_main  = 1'b0;
    ld_skid  = 1'b0;
    clr_main = 1'b0;
    if (Flush) begin
      state_nx = EMPTY;
      clr_main = 1'b1;
    end else
      case (state)
        EMPTY: if (acc) begin
          ld_main  = 1'b1;
          state_nx = ONE;
        end
        ONE: if (acc && xfer) ld_main = 1'b1;
          else if (acc) begin
            ld_skid  = 1'b1;
            state_nx = FULL;
          end else if (xfer) begin
            clr_main = 1'b1;
            state_nx = EMPTY;
          end
        FULL: if (xfer) begin
          ld_main  = 1'b1;
          state_nx = ONE;
        end
        default: state_nx = EMPTY;
      endcase
  end
  // ctrl is zeroed on every entry to EMPTY so OutCtrl needs no output gating
  d_ffec_n #(.W(CTRL_W)) u_main_ctrl (
    .clk(Clk), .clrn(Clrn), .en(ld_main | clr_main),
    .d(clr_main ? '0 : (state == FULL ? skid_ctrl : InCtrl)), .q(OutCtrl)
  );
  d_ffec_n #(.W(DATA_W)) u_main_data (
    .clk(Clk), .clrn(Clrn), .en(ld_main),
    .d(state == FULL ? skid_data : InData), .q(OutData)
  );
  d_ffec_n #(.W(CTRL_W)) u_skid_ctrl (
    .clk(Clk), .clrn(Clrn), .en(ld_skid | Flush),
    .d(Flush ? '0 : InCtrl), .q(skid_ctrl)
  );
  d_ffec_n #(.W(DATA_W)) u_skid_data (
    .clk(Clk), .clrn(Clrn), .en(ld_skid),
    .d(InData), .q(skid_data)
  );
  always_ff @(posedge Clk or negedge Clrn)
    if (!Clrn) StallCnt <= '0;
    else if (OutValid && !OutReady && StallCnt != '1) StallCnt <= StallCnt + 1'b1;
endmodule
